alu_arbiter: RTL and testbench

Shares the processor's single 16-bit add/sub ALU between two requesters: port 0 is the accumulator datapath (control unit) and port 1 is the PC/branch-target unit. It uses a two-way round-robin grant with one outstanding operation. The block drives the ALU's operand and op inputs, captures result and compare flags into registers, and returns them on a per-port valid/ready response channel. It sits between the control unit, the PC logic and the ALU instance.

---
 rtl/alu_pkg.sv | 15 +
 rtl/rr_pick2.sv | 23 ++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, legality check, arbiter states and default width.
package alu_pkg;

   localparam int ALU_DATA_W = 16;

   localparam logic [2:0] ALU_OP_ADD = 3'd0;
   localparam logic [2:0] ALU_OP_SUB = 3'd1;

   typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;

   function automatic logic alu_op_legal(input logic [2:0] op);
      return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; a held lock keeps the previous winner while it still requests.
module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   input  logic       lock,
   output logic       grant,
   output logic       any
);

   always_comb begin
      any   = |valid;
      grant = 1'b0;
      if (lock && valid[last]) begin
         grant = last;
      end else if (valid == 2'b11) begin
         grant = ~last;
      end else begin
         // single requester wins; with no requester port 0 is selected
         grant = valid[1] & ~valid[0];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one add/sub ALU between the control unit (port 0) and PC unit (port 1), one op in flight.
// Optional grant locking for multi-word sequences is enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b1,
   input  logic [2:0]        req_op0,
   input  logic [2:0]        req_op1,
`ifdef ALU_ARB_LOCK_EN
   input  logic [1:0]        req_lock,
`endif
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_eq,
   output logic              rsp_le,
   output logic              rsp_err,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_eq,
   input  logic              alu_le
);

   arb_state_t state, state_nxt;
   logic       last_grant;
   logic       owner;
   logic       grant;
   logic       any;
   logic       hs;
   logic       lock_use;

   rr_pick2 u_pick (
      .valid (req_valid),
      .last  (last_grant),
      .lock  (lock_use),
      .grant (grant),
      .any   (any)
   );

`ifdef ALU_ARB_LOCK_EN
   logic lock_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= 1'b0;
      end else if (hs) begin
         lock_q <= req_lock[grant];
      end else if (state == ARB_IDLE && lock_q && !req_valid[last_grant]) begin
         lock_q <= 1'b0;
      end
   end

   assign lock_use = lock_q;
`else
   assign lock_use = 1'b0;
`endif

   assign alu_a  = grant ? req_a1  : req_a0;
   assign alu_b  = grant ? req_b1  : req_b0;
   assign alu_op = grant ? req_op1 : req_op0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      hs        = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (any) begin
               req_ready[grant] = 1'b1;
               hs               = 1'b1;
               state_nxt        = ARB_RESP;
            end
         end
         ARB_RESP: begin
            rsp_valid[owner] = 1'b1;
            if (rsp_ready[owner]) begin
               state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // illegal op codes are undefined in the ALU, so its result is never trusted for them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         rsp_result <= '0;
         rsp_eq     <= 1'b0;
         rsp_le     <= 1'b0;
         rsp_err    <= 1'b0;
      end else if (hs) begin
         last_grant <= grant;
         owner      <= grant;
         rsp_result <= alu_op_legal(alu_op) ? alu_result : '0;
         rsp_eq     <= alu_eq;
         rsp_le     <= alu_le;
         rsp_err    <= ~alu_op_legal(alu_op);
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [15:0] a_in [2];
   logic [15:0] b_in [2];
   logic [2:0]  op_in [2];
   logic [1:0]  req_lock = 2'b00;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = 2'b00;
   logic [15:0] rsp_result;
   logic        rsp_eq, rsp_le, rsp_err;
   logic [15:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_op;
   logic        alu_eq, alu_le;

   int n_tests = 0;
   int n_fail  = 0;
   int gq[$];

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a0     (a_in[0]),
      .req_b0     (b_in[0]),
      .req_a1     (a_in[1]),
      .req_b1     (b_in[1]),
      .req_op0    (op_in[0]),
      .req_op1    (op_in[1]),
`ifdef ALU_ARB_LOCK_EN
      .req_lock   (req_lock),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_eq     (rsp_eq),
      .rsp_le     (rsp_le),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_eq     (alu_eq),
      .alu_le     (alu_le)
   );

   // ALU stand-in: undefined op codes return junk so a missing force-to-zero shows up
   always_comb begin
      case (alu_op)
         3'd0:    alu_result = alu_a + alu_b;
         3'd1:    alu_result = alu_a - alu_b;
         default: alu_result = (alu_a ^ alu_b) | 16'h0101;
      endcase
      alu_eq = (alu_a == alu_b);
      alu_le = ($signed(alu_a) <= $signed(alu_b));
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 16'h8000;
         1:       return 16'h7fff;
         2:       return 16'h0000;
         3:       return 16'hffff;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic new_req(input int p);
      a_in[p] = rnd_val();
      b_in[p] = ($urandom_range(0, 3) == 0) ? a_in[p] : rnd_val();
      op_in[p] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      req_lock[p] = 1'($urandom);
   endtask

   // ---------------- reference model: one outstanding op, round robin, optional lock
   bit          m_busy = 1'b0;
   int          m_owner = 0;
   int          m_last = 1;
   bit          m_lock = 1'b0;
   logic [15:0] m_res = 16'h0;
   logic        m_eq = 1'b0, m_le = 1'b0, m_err = 1'b0;
   logic [15:0] ea, eb;
   logic [2:0]  eo;
   int          g;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_last = 1; m_lock = 1'b0;
         m_res = 16'h0; m_eq = 1'b0; m_le = 1'b0; m_err = 1'b0;
      end else begin
         if (m_lock && req_valid[m_last]) g = m_last;
         else if (req_valid == 2'b11)     g = 1 - m_last;
         else if (req_valid[1])           g = 1;
         else                             g = 0;
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_eq", rsp_eq, m_eq);
         chk("rsp_le", rsp_le, m_le);
         chk("rsp_err", rsp_err, m_err);
         if (m_busy) begin
            chk("req_ready_busy", req_ready, 0);
            chk("rsp_valid_busy", rsp_valid, 1 << m_owner);
            if (rsp_ready[m_owner]) m_busy = 1'b0;
         end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("req_ready_idle", req_ready, (req_valid != 0) ? (1 << g) : 0);
            chk("alu_a", alu_a, a_in[g]);
            chk("alu_b", alu_b, b_in[g]);
            chk("alu_op", alu_op, op_in[g]);
            if (m_lock && !req_valid[m_last]) m_lock = 1'b0;
            if (req_valid != 0) begin
               ea = a_in[g]; eb = b_in[g]; eo = op_in[g];
               m_eq  = (ea == eb);
               m_le  = ($signed(ea) <= $signed(eb));
               m_err = (eo > 3'd1);
               m_res = (eo == 3'd0) ? ea + eb : (eo == 3'd1) ? ea - eb : 16'h0;
               m_busy = 1'b1; m_owner = g; m_last = g;
`ifdef ALU_ARB_LOCK_EN
               m_lock = req_lock[g];
`endif
            end
         end
      end
   end

   // both ports issue n0/n1 back-to-back requests; handshake order goes to gq
   task automatic run_seq(input int n0, input int n1, input logic lk);
      int left[2];
      int cyc;
      logic [1:0] hs;
      left[0] = n0; left[1] = n1;
      gq.delete();
      rsp_ready = 2'b11;
      for (int p = 0; p < 2; p++) begin
         new_req(p);
         req_valid[p] = (left[p] > 0);
      end
      req_lock = {1'b0, lk};
      cyc = 0;
      while ((left[0] + left[1]) > 0 && cyc < 100) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk); #1;
         cyc++;
         for (int p = 0; p < 2; p++) begin
            if (hs[p]) begin
               gq.push_back(p);
               left[p]--;
               if (left[p] > 0) new_req(p);
               else req_valid[p] = 1'b0;
            end
         end
         req_lock = {1'b0, lk};
      end
      chk("seq_no_timeout", cyc < 100, 1);
      repeat (2) begin @(posedge clk); #1; end
      req_lock = 2'b00;
   endtask

   initial begin
      logic [1:0] hs;
      logic [15:0] held;
      for (int p = 0; p < 2; p++) begin a_in[p] = 0; b_in[p] = 0; op_in[p] = 0; end

      // reset state
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 5 + 7 on port 0
      a_in[0] = 16'd5; b_in[0] = 16'd7; op_in[0] = 3'd0; req_valid = 2'b01;
      @(negedge clk);
      chk("add_req_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("add_rsp_valid", rsp_valid, 2'b01);
      chk("add_result", rsp_result, 16'd12);
      chk("add_eq", rsp_eq, 0);
      chk("add_le", rsp_le, 1);
      chk("add_err", rsp_err, 0);
      @(posedge clk); #1; rsp_ready = 2'b01;
      @(posedge clk); #1; rsp_ready = 2'b00;

      // 0x8000 - 1 on port 1 wraps to 0x7fff
      a_in[1] = 16'h8000; b_in[1] = 16'd1; op_in[1] = 3'd1; req_valid = 2'b10;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("sub_rsp_valid", rsp_valid, 2'b10);
      chk("sub_result", rsp_result, 16'h7fff);
      chk("sub_le", rsp_le, 1);
      @(posedge clk); #1; rsp_ready = 2'b11;
      @(posedge clk); #1; rsp_ready = 2'b00;

      // response back-pressure while port 1 waits
      a_in[0] = 16'd3; b_in[0] = 16'd3; op_in[0] = 3'd0; req_valid = 2'b01;
      @(posedge clk); #1;
      a_in[1] = 16'd10; b_in[1] = 16'd4; op_in[1] = 3'd1; req_valid = 2'b10;
      held = 16'd6;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req_ready1", req_ready[1], 0);
         chk("stall_result", rsp_result, held);
         @(posedge clk); #1;
      end
      rsp_ready = 2'b01;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      @(negedge clk);
      chk("after_accept_grant1", req_ready, 2'b10);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("p1_result", rsp_result, 16'd6);
      @(posedge clk); #1; rsp_ready = 2'b10;
      @(posedge clk); #1; rsp_ready = 2'b00;

      // illegal op, then reset in the middle of the response
      a_in[0] = 16'd9; b_in[0] = 16'd9; op_in[0] = 3'd5; req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("ill_err", rsp_err, 1);
      chk("ill_result", rsp_result, 0);
      chk("ill_rsp_valid", rsp_valid, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_result", rsp_result, 0);
      chk("midrst_err", rsp_err, 0);
      chk("midrst_eq", rsp_eq, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ties alternate 0,1,0,1,... starting with port 0 after reset
      run_seq(4, 4, 1'b0);
      chk("tie_count", gq.size(), 8);
      for (int i = 0; i < gq.size() && i < 8; i++) chk("tie_order", gq[i], i % 2);

`ifdef ALU_ARB_LOCK_EN
      rst_n = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_seq(3, 1, 1'b1);
      chk("lock_count", gq.size(), 4);
      for (int i = 0; i < gq.size() && i < 4; i++) chk("lock_order", gq[i], (i < 3) ? 0 : 1);
`endif

      // randomized traffic against the model
      req_valid = 2'b00; rsp_ready = 2'b00;
      repeat (3000) begin
         @(negedge clk);
         hs = req_valid & req_ready;
         @(posedge clk); #1;
         for (int p = 0; p < 2; p++) begin
            if (hs[p] || !req_valid[p]) begin
               if ($urandom_range(0, 2) == 0) begin
                  new_req(p);
                  req_valid[p] = 1'b1;
               end else begin
                  req_valid[p] = 1'b0;
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[p] = 1'b0;
            end
         end
         rsp_ready = 2'($urandom);
      end
      req_valid = 2'b00; rsp_ready = 2'b11;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
